// File: rtl/game_timebase.sv
// game_timebase
// Divides the system clock into a millisecond tick and a second tick, and
// keeps a seconds counter. The counter counts up and saturates at SEC_MAX,
// or counts down from a loaded value and stops at zero. The tick strobes and
// limit_pulse are registered single-cycle pulses. at_limit is a level that
// follows seconds and down combinationally.

module game_timebase #(
    parameter int CLK_DIV    = 100000,  // clock cycles per millisecond tick, >= 2
    parameter int MS_PER_SEC = 1000,    // millisecond ticks per second tick, >= 1
    parameter int SEC_WIDTH  = 10,      // width of seconds and load_val
    parameter int SEC_MAX    = 999      // saturation value, < 2**SEC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,       // synchronous, active low
    input  logic                 run,
    input  logic                 clear,
    input  logic                 load,
    input  logic [SEC_WIDTH-1:0] load_val,
    input  logic                 down,
    output logic                 tick_ms,
    output logic                 tick_s,
    output logic [SEC_WIDTH-1:0] seconds,
    output logic                 at_limit,
    output logic                 limit_pulse
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

    localparam logic [PS_W-1:0]      PS_LAST   = PS_W'(CLK_DIV - 1);
    localparam logic [PS_W-1:0]      PS_ONE    = PS_W'(1);
    localparam logic [MS_W-1:0]      MS_LAST   = MS_W'(MS_PER_SEC - 1);
    localparam logic [MS_W-1:0]      MS_ONE    = MS_W'(1);
    localparam logic [SEC_WIDTH-1:0] SEC_LIMIT = SEC_WIDTH'(SEC_MAX);
    localparam logic [SEC_WIDTH-1:0] SEC_ONE   = SEC_WIDTH'(1);

    // ------------------------------------------------------------------
    // Internal state and next-state helpers
    // ------------------------------------------------------------------
    logic [PS_W-1:0]      ps;            // cycle prescaler, 0..CLK_DIV-1
    logic [MS_W-1:0]      ms;            // millisecond count, 0..MS_PER_SEC-1
    logic                 ps_wrap;       // prescaler is on its last count
    logic                 ms_wrap;       // ms count is on its last count
    logic                 ms_fire;       // this edge registers tick_ms
    logic                 sec_fire;      // this edge registers tick_s
    logic [SEC_WIDTH-1:0] sec_step;      // seconds value after one tick_s
    logic                 sec_reach;     // the step lands on the active limit
    logic [SEC_WIDTH-1:0] load_clamped;  // load_val limited to SEC_MAX

    assign ps_wrap  = (ps == PS_LAST);
    assign ms_wrap  = (ms == MS_LAST);
    assign ms_fire  = run && ps_wrap;
    assign sec_fire = ms_fire && ms_wrap;

    assign load_clamped = (load_val > SEC_LIMIT) ? SEC_LIMIT : load_val;

    // Level indicator: which end counts as the limit depends on the direction.
    assign at_limit = down ? (seconds == '0) : (seconds == SEC_LIMIT);

    // Saturating one-second step in the current direction; flags the step
    // that lands on the limit so the pulse fires only on arrival, never while
    // already parked there.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sec_step  = seconds;
        sec_reach = 1'b0;
        if (down) begin
            if (seconds != '0) begin
                sec_step  = seconds - SEC_ONE;
                sec_reach = (sec_step == '0);
            end
        end else begin
            if (seconds < SEC_LIMIT) begin
                sec_step  = seconds + SEC_ONE;
                sec_reach = (sec_step == SEC_LIMIT);
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and millisecond counter
    // ------------------------------------------------------------------

    // Advance ps every running cycle and ms on each ps wrap; load and clear
    // both restart the divider chain from zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            ps <= '0;
            ms <= '0;
        end else if (load || clear) begin
            ps <= '0;
            ms <= '0;
        end else if (run) begin
            if (ps_wrap) begin
                ps <= '0;
                ms <= ms_wrap ? '0 : ms + MS_ONE;
            end else begin
                ps <= ps + PS_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Seconds counter
    // ------------------------------------------------------------------

    // Seconds moves on the same edge that registers tick_s, so the new value
    // is visible in the cycle where tick_s is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seconds <= '0;
        end else if (load) begin
            seconds <= load_clamped;
        end else if (clear) begin
            seconds <= '0;
        end else if (sec_fire) begin
            seconds <= sec_step;
        end
    end

    // ------------------------------------------------------------------
    // Strobes
    // ------------------------------------------------------------------

    // Single-cycle strobes; load, clear and a frozen timebase all suppress
    // them, so a load on a tick edge emits nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_ms     <= 1'b0;
            tick_s      <= 1'b0;
            limit_pulse <= 1'b0;
        end else if (load || clear) begin
            tick_ms     <= 1'b0;
            tick_s      <= 1'b0;
            limit_pulse <= 1'b0;
        end else begin
            tick_ms     <= ms_fire;
            tick_s      <= sec_fire;
            limit_pulse <= sec_fire && sec_reach;
        end
    end

endmodule

// File: tb/tb_game_timebase.sv
// tb_game_timebase
// Directed bench for game_timebase with CLK_DIV=4, MS_PER_SEC=3, SEC_WIDTH=4,
// SEC_MAX=5. Each task drives one scenario and compares outputs against
// hand-computed expectations. Inputs change and outputs are sampled 1 time
// unit after each rising edge.

module tb_game_timebase;

    localparam int CLK_DIV    = 4;
    localparam int MS_PER_SEC = 3;
    localparam int SEC_WIDTH  = 4;
    localparam int SEC_MAX    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 run;
    logic                 clear;
    logic                 load;
    logic [SEC_WIDTH-1:0] load_val;
    logic                 down;
    logic                 tick_ms;
    logic                 tick_s;
    logic [SEC_WIDTH-1:0] seconds;
    logic                 at_limit;
    logic                 limit_pulse;

    int vectors     = 0;
    int miscompares = 0;

    game_timebase #(
        .CLK_DIV    (CLK_DIV),
        .MS_PER_SEC (MS_PER_SEC),
        .SEC_WIDTH  (SEC_WIDTH),
        .SEC_MAX    (SEC_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .load        (load),
        .load_val    (load_val),
        .down        (down),
        .tick_ms     (tick_ms),
        .tick_s      (tick_s),
        .seconds     (seconds),
        .at_limit    (at_limit),
        .limit_pulse (limit_pulse)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held low together with load and run: everything reads zero.
    task automatic test_reset();
        reset    = 1'b0;
        load     = 1'b1;
        load_val = 4'd3;
        run      = 1'b1;
        clear    = 1'b0;
        down     = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (seconds !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_seconds k=%0d got=%0d exp=0", k, seconds);
            end
            vectors++;
            if (tick_ms !== 1'b0 || tick_s !== 1'b0 || limit_pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_strobes k=%0d got ms=%b s=%b lp=%b exp=000",
                         k, tick_ms, tick_s, limit_pulse);
            end
            vectors++;
            if (at_limit !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_at_limit k=%0d got=%b exp=0", k, at_limit);
            end
        end
    endtask

    // Release reset with run high, count up through saturation at 5.
    task automatic test_count_up();
        int exp_sec;
        reset = 1'b1;
        load  = 1'b0;
        run   = 1'b1;
        down  = 1'b0;
        for (int k = 1; k <= 72; k++) begin
            step();
            exp_sec = (k / 12 > SEC_MAX) ? SEC_MAX : k / 12;
            vectors++;
            if (tick_ms !== (k % 4 == 0)) begin
                miscompares++;
                $display("FAIL up_tick_ms k=%0d got=%b exp=%b", k, tick_ms, (k % 4 == 0));
            end
            vectors++;
            if (tick_s !== (k % 12 == 0)) begin
                miscompares++;
                $display("FAIL up_tick_s k=%0d got=%b exp=%b", k, tick_s, (k % 12 == 0));
            end
            vectors++;
            if (seconds !== SEC_WIDTH'(exp_sec)) begin
                miscompares++;
                $display("FAIL up_seconds k=%0d got=%0d exp=%0d", k, seconds, exp_sec);
            end
            vectors++;
            if (limit_pulse !== (k == 60)) begin
                miscompares++;
                $display("FAIL up_limit_pulse k=%0d got=%b exp=%b", k, limit_pulse, (k == 60));
            end
            vectors++;
            if (at_limit !== (k >= 60)) begin
                miscompares++;
                $display("FAIL up_at_limit k=%0d got=%b exp=%b", k, at_limit, (k >= 60));
            end
        end
    endtask

    // Load 3, count down to 0 and hold; then flip to up mode at the limit.
    task automatic test_count_down();
        int exp_sec;
        load     = 1'b1;
        load_val = 4'd3;
        down     = 1'b1;
        run      = 1'b1;
        step();
        vectors++;
        if (seconds !== 4'd3 || tick_ms !== 1'b0 || tick_s !== 1'b0 || limit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL down_load got sec=%0d ms=%b s=%b lp=%b exp sec=3 strobes=000",
                     seconds, tick_ms, tick_s, limit_pulse);
        end
        load = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            step();
            exp_sec = (3 - k / 12 < 0) ? 0 : 3 - k / 12;
            vectors++;
            if (tick_s !== (k % 12 == 0)) begin
                miscompares++;
                $display("FAIL down_tick_s k=%0d got=%b exp=%b", k, tick_s, (k % 12 == 0));
            end
            vectors++;
            if (seconds !== SEC_WIDTH'(exp_sec)) begin
                miscompares++;
                $display("FAIL down_seconds k=%0d got=%0d exp=%0d", k, seconds, exp_sec);
            end
            vectors++;
            if (limit_pulse !== (k == 36)) begin
                miscompares++;
                $display("FAIL down_limit_pulse k=%0d got=%b exp=%b", k, limit_pulse, (k == 36));
            end
            vectors++;
            if (at_limit !== (k >= 36)) begin
                miscompares++;
                $display("FAIL down_at_limit k=%0d got=%b exp=%b", k, at_limit, (k >= 36));
            end
        end
        // Parked at 0; switching to up mode clears at_limit at once and the
        // next tick_s (12 edges later) moves seconds to 1 without a pulse.
        down = 1'b0;
        #1;
        vectors++;
        if (at_limit !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_switch_at_limit got=%b exp=0", at_limit);
        end
        repeat (12) step();
        vectors++;
        if (seconds !== 4'd1 || tick_s !== 1'b1 || limit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_switch_step got sec=%0d s=%b lp=%b exp sec=1 s=1 lp=0",
                     seconds, tick_s, limit_pulse);
        end
    endtask

    // Clamp on load, load over clear, clear alone, load on a tick edge.
    task automatic test_priority();
        run      = 1'b1;
        down     = 1'b0;
        load     = 1'b1;
        load_val = 4'd15;
        step();
        vectors++;
        if (seconds !== 4'd5 || at_limit !== 1'b1 || limit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp got sec=%0d al=%b lp=%b exp sec=5 al=1 lp=0",
                     seconds, at_limit, limit_pulse);
        end
        clear    = 1'b1;
        load_val = 4'd2;
        step();
        vectors++;
        if (seconds !== 4'd2) begin
            miscompares++;
            $display("FAIL load_over_clear got=%0d exp=2", seconds);
        end
        load = 1'b0;
        step();
        vectors++;
        if (seconds !== 4'd0) begin
            miscompares++;
            $display("FAIL clear got=%0d exp=0", seconds);
        end
        clear    = 1'b0;
        load     = 1'b1;
        load_val = 4'd0;
        step();
        load = 1'b0;
        repeat (3) step();
        // ps is now 3: the next running edge would tick, but load takes it.
        load     = 1'b1;
        load_val = 4'd4;
        step();
        vectors++;
        if (tick_ms !== 1'b0 || seconds !== 4'd4) begin
            miscompares++;
            $display("FAIL load_on_tick got ms=%b sec=%0d exp ms=0 sec=4", tick_ms, seconds);
        end
        load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (tick_ms !== (k == 4)) begin
                miscompares++;
                $display("FAIL after_load_tick_ms k=%0d got=%b exp=%b", k, tick_ms, (k == 4));
            end
        end
    endtask

    // Freeze for 7 cycles just before the first tick_ms; every tick slips by 7.
    task automatic test_pause();
        int j;
        bit exp_ms;
        bit exp_s;
        load     = 1'b1;
        load_val = 4'd0;
        down     = 1'b0;
        run      = 1'b1;
        step();
        load = 1'b0;
        j = 0;
        for (int e = 1; e <= 30; e++) begin
            run = !(e >= 4 && e <= 10);
            step();
            if (run) j++;
            exp_ms = run && (j % 4 == 0);
            exp_s  = run && (j % 12 == 0);
            vectors++;
            if (tick_ms !== exp_ms) begin
                miscompares++;
                $display("FAIL pause_tick_ms e=%0d got=%b exp=%b", e, tick_ms, exp_ms);
            end
            vectors++;
            if (tick_s !== exp_s) begin
                miscompares++;
                $display("FAIL pause_tick_s e=%0d got=%b exp=%b", e, tick_s, exp_s);
            end
            vectors++;
            if (seconds !== SEC_WIDTH'(j / 12)) begin
                miscompares++;
                $display("FAIL pause_seconds e=%0d got=%0d exp=%0d", e, seconds, j / 12);
            end
        end
        run = 1'b1;
    endtask

    // Reset with ps=2, ms=1, seconds=3; counters restart from zero.
    task automatic test_mid_reset();
        load     = 1'b1;
        load_val = 4'd3;
        down     = 1'b0;
        run      = 1'b1;
        step();
        load = 1'b0;
        repeat (6) step();
        reset = 1'b0;
        step();
        vectors++;
        if (seconds !== 4'd0 || tick_ms !== 1'b0 || tick_s !== 1'b0 ||
            limit_pulse !== 1'b0 || at_limit !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got sec=%0d ms=%b s=%b lp=%b al=%b exp all 0",
                     seconds, tick_ms, tick_s, limit_pulse, at_limit);
        end
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++;
            if (tick_ms !== (k % 4 == 0)) begin
                miscompares++;
                $display("FAIL post_reset_tick_ms k=%0d got=%b exp=%b", k, tick_ms, (k % 4 == 0));
            end
            vectors++;
            if (tick_s !== (k == 12) || seconds !== ((k == 12) ? 4'd1 : 4'd0)) begin
                miscompares++;
                $display("FAIL post_reset_sec k=%0d got s=%b sec=%0d exp s=%b sec=%0d",
                         k, tick_s, seconds, (k == 12), (k == 12) ? 1 : 0);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        run      = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        down     = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_priority();
        test_pause();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
